// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion and flush-to-bubble conversion.
// Optional bubble counters are compiled in with `define ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 22
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              hazard_stall,
  output logic              flush_eff
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lu_bubbles,
  output logic [31:0]       perf_fl_bubbles
`endif
);

  // MemRead is the fourth field from the MSB of the packed control bundle
  localparam int MEMREAD_BIT = CTRL_W - 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic kill_pending;
  logic uses_rs1;
  logic uses_rs2;
  logic load_use;
  logic bubble;

  always_comb begin
    uses_rs1     = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
    uses_rs2     = (id_opcode == OP_R) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
    load_use     = ex_valid && ex_ctrl[MEMREAD_BIT] && (ex_rd != 5'd0) && id_valid &&
                   ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
    flush_eff    = ex_flush | kill_pending;
    hazard_stall = load_use & ~flush_eff;
    bubble       = flush_eff | load_use;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      kill_pending <= 1'b0;
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7    <= '0;
    end else if (mem_stall) begin
      // a flush seen while stalled must survive until the register can move
      if (ex_flush) kill_pending <= 1'b1;
    end else begin
      kill_pending <= 1'b0;
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_ctrl     <= '0;
        ex_pc       <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct3   <= '0;
        ex_funct7   <= '0;
      end else begin
        ex_valid    <= id_valid;
        // decoder may emit X for illegal opcodes; never let it reach write enables
        ex_ctrl     <= id_valid ? id_ctrl : '0;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct3   <= id_funct3;
        ex_funct7   <= id_funct7;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_lu_bubbles <= '0;
      perf_fl_bubbles <= '0;
    end else if (!mem_stall) begin
      if (flush_eff)     perf_fl_bubbles <= perf_fl_bubbles + 32'd1;
      else if (load_use) perf_lu_bubbles <= perf_lu_bubbles + 32'd1;
    end
  end
`endif

endmodule
